// File: rtl/hazard_sequencer_if.sv
// Handshake bundle between the ID-stage hazard sequencer and the pipeline registers/PC.
// The master modport is the sequencer side; the slave modport is the pipeline side.
interface hazard_sequencer_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             ex_mem_read;
   logic [4:0]       ex_rd;
   logic             ex_branch_taken;
   logic             id_halt;
   logic             mem_busy;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             pipe_freeze;
   logic             halted;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      input  id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, id_halt, mem_busy,
      output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze,
             halted, stall_count, flush_count
   );

   modport slave (
      output id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, id_halt, mem_busy,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze,
             halted, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing for the 5-stage core: memory-wait freeze, branch flush,
// load-use bubble, HALT drain, and saturating stall/flush event counters.
module hazard_sequencer #(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic               clk,
   input  logic               reset,
   hazard_sequencer_if.master bus
);
   localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } state_t;

   state_t             state_reg, state_next;
   logic [DCNT_W-1:0]  drain_cnt_reg, drain_cnt_next;
   logic               halted_reg;
   logic [CNT_W-1:0]   stall_count_reg;
   logic [CNT_W-1:0]   flush_count_reg;

   logic               pc_write;
   logic               if_id_write;
   logic               if_id_flush;
   logic               id_ex_flush;
   logic               pipe_freeze;
   logic               stall_inc;
   logic               flush_inc;

   logic [4:0]         src_reg [2];
   logic [1:0]         src_match;
   logic               load_use;

   assign src_reg[0] = bus.id_rs1;
   assign src_reg[1] = bus.id_rs2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
         assign src_match[gi] = (bus.ex_rd == src_reg[gi]);
      end
   endgenerate

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) && (|src_match);

   always_comb begin
      state_next     = state_reg;
      drain_cnt_next = drain_cnt_reg;
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      pipe_freeze    = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      case (state_reg)
         RUN: begin
            if (bus.mem_busy) begin
               pipe_freeze = 1'b1;
               stall_inc   = 1'b1;
            end else if (bus.ex_branch_taken) begin
               // A HALT sitting in ID here is wrong-path and is flushed with the rest.
               pc_write    = 1'b1;
               if_id_write = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               flush_inc   = 1'b1;
            end else if (load_use) begin
               id_ex_flush = 1'b1;
               stall_inc   = 1'b1;
            end else if (bus.id_halt) begin
               id_ex_flush    = 1'b1;
               drain_cnt_next = DRAIN_LOAD;
               state_next     = DRAIN;
            end else begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
            end
         end

         DRAIN: begin
            id_ex_flush = 1'b1;
            if (bus.mem_busy) begin
               pipe_freeze = 1'b1;
               stall_inc   = 1'b1;
            end else if (drain_cnt_reg == '0) begin
               state_next = HALTED;
            end else begin
               drain_cnt_next = drain_cnt_reg - DCNT_W'(1);
            end
         end

         HALTED: begin
            id_ex_flush = 1'b1;
         end

         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= RUN;
         drain_cnt_reg   <= '0;
         halted_reg      <= 1'b0;
         stall_count_reg <= '0;
         flush_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         drain_cnt_reg <= drain_cnt_next;
         halted_reg    <= (state_next == HALTED);
         if (stall_inc && (stall_count_reg != CNT_MAX)) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
         end
         if (flush_inc && (flush_count_reg != CNT_MAX)) begin
            flush_count_reg <= flush_count_reg + CNT_W'(1);
         end
      end
   end

   assign bus.pc_write    = pc_write;
   assign bus.if_id_write = if_id_write;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.pipe_freeze = pipe_freeze;
   assign bus.halted      = halted_reg;
   assign bus.stall_count = stall_count_reg;
   assign bus.flush_count = flush_count_reg;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: table of single-cycle RUN vectors plus
// hand-written HALT, DRAIN-freeze, async-reset and counter-saturation sequences.
module tb_hazard_sequencer;
   logic clk;
   logic reset;

   hazard_sequencer_if #(.CNT_W(16)) bus0 ();
   hazard_sequencer_if #(.CNT_W(4))  bus1 ();

   hazard_sequencer #(.CNT_W(16), .DRAIN_CYCLES(3)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   hazard_sequencer #(.CNT_W(4), .DRAIN_CYCLES(3)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}
   typedef struct {
      string      name;
      logic       mem_busy;
      logic       br;
      logic       mrd;
      logic [4:0] ex_rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       halt;
      logic [4:0] exp_ctl;
      int         d_stall;
      int         d_flush;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(string name, logic mb, logic br, logic mrd, logic [4:0] exrd,
                               logic [4:0] rs1, logic [4:0] rs2, logic halt,
                               logic [4:0] ctl, int ds, int df);
      vec_t v;
      v.name = name; v.mem_busy = mb; v.br = br; v.mrd = mrd; v.ex_rd = exrd;
      v.rs1 = rs1; v.rs2 = rs2; v.halt = halt; v.exp_ctl = ctl;
      v.d_stall = ds; v.d_flush = df;
      return v;
   endfunction

   function automatic logic [4:0] ctl0();
      return {bus0.pc_write, bus0.if_id_write, bus0.if_id_flush, bus0.id_ex_flush,
              bus0.pipe_freeze};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      n_total++;
      if (act !== req) begin
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         n_pass++;
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   task automatic drive0(logic mb, logic br, logic mrd, logic [4:0] exrd,
                         logic [4:0] rs1, logic [4:0] rs2, logic halt);
      bus0.mem_busy        = mb;
      bus0.ex_branch_taken = br;
      bus0.ex_mem_read     = mrd;
      bus0.ex_rd           = exrd;
      bus0.id_rs1          = rs1;
      bus0.id_rs2          = rs2;
      bus0.id_halt         = halt;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset between clock edges and checks the reset values without any edge.
   task automatic async_reset(string tag);
      #3;
      reset = 1'b0;
      #1;
      chk({tag, "_ctl"}, 32'(ctl0()), 32'b11000);
      chk({tag, "_halted"}, 32'(bus0.halted), 32'd0);
      chk({tag, "_stall"}, 32'(bus0.stall_count), 32'd0);
      chk({tag, "_flush"}, 32'(bus0.flush_count), 32'd0);
      #1;
      reset = 1'b1;
      exp_stall = 0;
      exp_flush = 0;
   endtask

   initial begin
      reset = 1'b0;
      drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      bus1.mem_busy = 1'b0; bus1.ex_branch_taken = 1'b0; bus1.ex_mem_read = 1'b0;
      bus1.ex_rd = 5'd0; bus1.id_rs1 = 5'd0; bus1.id_rs2 = 5'd0; bus1.id_halt = 1'b0;

      vecs[0]  = mk("idle",          0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'b11000, 0, 0);
      vecs[1]  = mk("loaduse_rs2",   0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 5'b00010, 1, 0);
      vecs[2]  = mk("load_x0",       0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 5'b11000, 0, 0);
      vecs[3]  = mk("loaduse_rs1",   0, 0, 1, 5'd7, 5'd7, 5'd2, 0, 5'b00010, 1, 0);
      vecs[4]  = mk("noload_match",  0, 0, 0, 5'd7, 5'd7, 5'd7, 0, 5'b11000, 0, 0);
      vecs[5]  = mk("branch_halt",   0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 5'b11110, 0, 1);
      vecs[6]  = mk("busy_loaduse",  1, 0, 1, 5'd9, 5'd9, 5'd0, 0, 5'b00001, 1, 0);
      vecs[7]  = mk("busy_branch",   1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 5'b00001, 1, 0);
      vecs[8]  = mk("branch_after",  0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 5'b11110, 0, 1);
      vecs[9]  = mk("loaduse_halt",  0, 0, 1, 5'd3, 5'd4, 5'd3, 1, 5'b00010, 1, 0);
      vecs[10] = mk("busy_halt",     1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'b00001, 1, 0);
      vecs[11] = mk("load_nomatch",  0, 0, 1, 5'd3, 5'd4, 5'd5, 0, 5'b11000, 0, 0);

      // Reset state with all inputs low, no clock edge needed.
      #2;
      chk("rst_ctl", 32'(ctl0()), 32'b11000);
      chk("rst_halted", 32'(bus0.halted), 32'd0);
      chk("rst_stall", 32'(bus0.stall_count), 32'd0);
      chk("rst_flush", 32'(bus0.flush_count), 32'd0);
      #10;
      reset = 1'b1;
      edge1();

      // Single-cycle RUN vectors; a following vector with a normal expectation
      // also confirms the previous one left the FSM in RUN.
      for (int i = 0; i < 12; i++) begin
         drive0(vecs[i].mem_busy, vecs[i].br, vecs[i].mrd, vecs[i].ex_rd,
                vecs[i].rs1, vecs[i].rs2, vecs[i].halt);
         @(negedge clk);
         chk({vecs[i].name, "_ctl"}, 32'(ctl0()), 32'(vecs[i].exp_ctl));
         edge1();
         exp_stall += vecs[i].d_stall;
         exp_flush += vecs[i].d_flush;
         chk({vecs[i].name, "_stall"}, 32'(bus0.stall_count), 32'(exp_stall));
         chk({vecs[i].name, "_flush"}, 32'(bus0.flush_count), 32'(exp_flush));
         chk({vecs[i].name, "_halted"}, 32'(bus0.halted), 32'd0);
      end
      drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("post_table_run", 32'(ctl0()), 32'b11000);
      edge1();

      // HALT for one cycle: halted rises on the 4th edge, PC frozen throughout.
      drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      @(negedge clk);
      chk("halt_accept_ctl", 32'(ctl0()), 32'b00010);
      for (int k = 1; k <= 4; k++) begin
         edge1();
         bus0.id_halt = 1'b0;
         chk($sformatf("halt_edge%0d_halted", k), 32'(bus0.halted), 32'(k == 4));
         @(negedge clk);
         chk($sformatf("halt_edge%0d_pcw", k), 32'(bus0.pc_write), 32'd0);
      end
      for (int k = 0; k < 20; k++) begin
         edge1();
         chk($sformatf("halted_hold%0d", k), 32'(bus0.halted), 32'd1);
         @(negedge clk);
         chk($sformatf("halted_ctl%0d", k), 32'(ctl0()), 32'b00010);
      end
      chk("halted_stall", 32'(bus0.stall_count), 32'(exp_stall));

      // Reset from HALTED, then a HALT whose drain sees two mem_busy cycles.
      edge1();
      async_reset("rst_from_halted");
      edge1();
      drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      edge1();
      drive0(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("drain_busy1_ctl", 32'(ctl0()), 32'b00011);
      edge1();
      chk("drain_busy1_halted", 32'(bus0.halted), 32'd0);
      @(negedge clk);
      chk("drain_busy2_ctl", 32'(ctl0()), 32'b00011);
      edge1();
      bus0.mem_busy = 1'b0;
      for (int k = 3; k <= 5; k++) begin
         @(negedge clk);
         if (k < 5) chk($sformatf("drain_e%0d_ctl", k + 1), 32'(ctl0()), 32'b00010);
         edge1();
         chk($sformatf("drain_e%0d_halted", k + 1), 32'(bus0.halted), 32'(k == 5));
      end
      chk("drain_busy_stall", 32'(bus0.stall_count), 32'd2);

      // Reset again, take one load-use stall, then abort a HALT drain with reset.
      async_reset("rst_again");
      edge1();
      drive0(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
      edge1();
      drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      chk("pre_drain_stall", 32'(bus0.stall_count), 32'd1);
      edge1();
      bus0.id_halt = 1'b0;
      @(negedge clk);
      chk("mid_drain_ctl", 32'(ctl0()), 32'b00010);
      edge1();
      async_reset("rst_mid_drain");
      edge1();
      chk("after_drain_rst_halted", 32'(bus0.halted), 32'd0);
      @(negedge clk);
      chk("after_drain_rst_ctl", 32'(ctl0()), 32'b11000);

      // Saturation on the 4-bit instance, with a load-use hazard alongside mem_busy.
      edge1();
      bus1.mem_busy = 1'b1; bus1.ex_mem_read = 1'b1; bus1.ex_rd = 5'd6; bus1.id_rs1 = 5'd6;
      @(negedge clk);
      chk("sat_ctl", 32'({bus1.pc_write, bus1.if_id_write, bus1.if_id_flush,
                          bus1.id_ex_flush, bus1.pipe_freeze}), 32'b00001);
      for (int k = 1; k <= 20; k++) begin
         edge1();
         if (k == 5)  chk("sat_stall5", 32'(bus1.stall_count), 32'd5);
         if (k == 15) chk("sat_stall15", 32'(bus1.stall_count), 32'd15);
      end
      chk("sat_stall20", 32'(bus1.stall_count), 32'd15);
      chk("sat_flush", 32'(bus1.flush_count), 32'd0);
      bus1.mem_busy = 1'b0; bus1.ex_mem_read = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
